uart_tx_fifo: RTL and testbench

Byte-wide transmit buffer that sits directly upstream of the UART top level. It accepts bytes from the host or bus side at up to one per clock and stores them in a circular FIFO. It launches them one at a time into the UART transmitter through that block's tx_data / tx_begin / tx_busy handshake. This lets the host burst-write a message without polling the transmitter between bytes.

---
 rtl/uart_tx_fifo.sv | 69 ++++++
 tb/tb_uart_tx_fifo.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: circular byte FIFO that launches queued bytes into a UART
// transmitter through the tx_data / tx_begin / tx_busy handshake.
module uart_tx_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [7:0]            wr_data,
    input  logic                  wr_en,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow,
    input  logic                  ovf_clear,
    output logic [7:0]            tx_data,
    output logic                  tx_begin,
    input  logic                  tx_busy,
    output logic                  idle
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] LAUNCH    = 2'd1;
    localparam logic [1:0] WAIT_BUSY = 2'd2;
    localparam logic [1:0] WAIT_DONE = 2'd3;

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [1:0]            state;
    logic                  push;
    logic                  pop;

    assign full  = count == FULL_COUNT;
    assign empty = count == '0;
    assign idle  = empty && state == IDLE;
    assign push  = wr_en && !full;
    assign pop   = state == IDLE && !empty;

    // Storage is not cleared by reset; the pointers alone define what is valid.
    always_ff @(posedge clock)
        if (push) mem[wr_ptr] <= wr_data;

    always_ff @(posedge clock) begin
        if (!reset) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            state    <= IDLE;
            tx_data  <= 8'h00;
            tx_begin <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
            if (pop) begin
                rd_ptr  <= rd_ptr + DEPTH_LOG2'(1);
                tx_data <= mem[rd_ptr];
            end
            count    <= count + (DEPTH_LOG2+1)'(push) - (DEPTH_LOG2+1)'(pop);
            // A fresh overflow in the same cycle beats ovf_clear.
            overflow <= (wr_en && full) || (overflow && !ovf_clear);
            tx_begin <= state == LAUNCH;
            state    <= pop                             ? LAUNCH    :
                        state == LAUNCH                 ? WAIT_BUSY :
                        (state == WAIT_BUSY && tx_busy) ? WAIT_DONE :
                        (state == WAIT_DONE && !tx_busy) ? IDLE     : state;
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed vectors plus randomized traffic against a queue
// model of the FIFO and a behavioural UART transmitter.
module tb_uart_tx_fifo;
    localparam int DEPTH = 16;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] wr_data;
    logic       wr_en;
    logic       full;
    logic       empty;
    logic [4:0] count;
    logic       overflow;
    logic       ovf_clear;
    logic [7:0] tx_data;
    logic       tx_begin;
    logic       idle;
    logic       busy_line;

    logic       mdl_busy = 1'b0;
    logic       active = 1'b0;
    logic       hold_busy;
    int         dly = 0;
    int         len = 0;
    int         busy_delay;
    int         busy_len;
    logic       rnd_busy;

    int         checks = 0;
    int         errors = 0;
    int         n_begin = 0;
    int         n_wr = 0;
    int         phase = 0;
    logic [7:0] prev_data = 8'h00;
    logic [7:0] exp_q [$];

    typedef struct {
        logic       we;
        logic [7:0] d;
        logic       clr;
        int         cnt;
        logic       fl;
        logic       ovf;
    } vec_t;
    vec_t tbl [21];

    assign busy_line = mdl_busy | hold_busy;

    uart_tx_fifo #(.DEPTH_LOG2(4)) dut (
        .clock(clock), .reset(reset), .wr_data(wr_data), .wr_en(wr_en),
        .full(full), .empty(empty), .count(count), .overflow(overflow),
        .ovf_clear(ovf_clear), .tx_data(tx_data), .tx_begin(tx_begin),
        .tx_busy(busy_line), .idle(idle)
    );

    always #5 clock = ~clock;

    // Transmitter: after tx_begin waits dly cycles, then stays busy len cycles.
    always @(posedge clock) begin
        if (tx_begin) begin
            active <= 1'b1;
            dly    <= rnd_busy ? int'($urandom_range(0, 3)) : busy_delay;
            len    <= rnd_busy ? int'($urandom_range(1, 20)) : busy_len;
        end else if (active && !mdl_busy) begin
            if (dly == 0) mdl_busy <= 1'b1;
            else dly <= dly - 1;
        end else if (mdl_busy) begin
            if (len <= 1) begin
                mdl_busy <= 1'b0;
                active   <= 1'b0;
            end else len <= len - 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // One clock; at the falling edge the scoreboard inspects the transmit side.
    task automatic tick();
        logic [7:0] e;
        @(negedge clock);
        if (phase == 2 && busy_line && reset) chk("tx_data_stable", tx_data, prev_data);
        if (tx_begin) begin
            n_begin++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL tx_begin_unexpected actual=%0h required=none", tx_data);
            end else begin
                e = exp_q.pop_front();
                if (tx_data !== e) begin
                    errors++;
                    $display("FAIL tx_data_order actual=%0h required=%0h", tx_data, e);
                end
            end
            chk("handshake_gap", phase == 0, 1);
            phase = 1;
        end else if (phase == 1 && busy_line) phase = 2;
        else if (phase == 2 && !busy_line) phase = 0;
        prev_data = tx_data;
        #1;
    endtask

    task automatic put(input logic [7:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        exp_q.push_back(d);
        n_wr++;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!(idle && !busy_line) && n < budget);
        chk({tag, "_idle"}, idle && !busy_line, 1);
        chk({tag, "_drained"}, exp_q.size(), 0);
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_full"}, full, 0);
        chk({tag, "_empty"}, empty, 1);
        chk({tag, "_count"}, count, 0);
        chk({tag, "_overflow"}, overflow, 0);
        chk({tag, "_tx_data"}, tx_data, 0);
        chk({tag, "_tx_begin"}, tx_begin, 0);
        chk({tag, "_idle"}, idle, 1);
    endtask

    initial begin
        int b0, wb, ub, pc;
        reset = 1'b0; wr_en = 1'b0; wr_data = 8'h00; ovf_clear = 1'b0;
        hold_busy = 1'b0; busy_delay = 0; busy_len = 3; rnd_busy = 1'b0;
        tick(); tick();
        reset = 1'b1;
        tick();
        chk_reset_values("rst");

        // Single byte latency: write at T, pop at T+1, tx_begin after T+2.
        put(8'hA5);
        chk("lat_empty_T", empty, 0);
        chk("lat_begin_T", tx_begin, 0);
        tick();
        chk("lat_empty_T1", empty, 1);
        chk("lat_begin_T1", tx_begin, 0);
        tick();
        chk("lat_begin_T2", tx_begin, 1);
        chk("lat_data", tx_data, 8'hA5);
        tick();
        chk("lat_begin_T3", tx_begin, 0);
        wait_idle(200, "lat");

        // Burst against a slow transmitter.
        busy_len = 160;
        b0 = n_begin;
        for (int i = 0; i < 16; i++) put(8'(i));
        wait_idle(4000, "burst");
        chk("burst_begins", n_begin - b0, 16);
        busy_len = 3;

        // Fill to full with the transmitter held busy, then overflow / clear.
        for (int i = 0; i < 17; i++)
            tbl[i] = '{1'b1, 8'(i), 1'b0, (i == 0) ? 1 : i, i == 16, 1'b0};
        tbl[17] = '{1'b1, 8'hEE, 1'b0, 16, 1'b1, 1'b1};
        tbl[18] = '{1'b0, 8'h00, 1'b1, 16, 1'b1, 1'b0};
        tbl[19] = '{1'b1, 8'hEE, 1'b1, 16, 1'b1, 1'b1};
        tbl[20] = '{1'b0, 8'h00, 1'b1, 16, 1'b1, 1'b0};
        hold_busy = 1'b1;
        tick();
        for (int i = 0; i < 21; i++) begin
            wr_en = tbl[i].we; wr_data = tbl[i].d; ovf_clear = tbl[i].clr;
            pc = (i == 0) ? 0 : tbl[i-1].cnt;
            if (tbl[i].we && pc < DEPTH) begin
                exp_q.push_back(tbl[i].d);
                n_wr++;
            end
            tick();
            chk($sformatf("vec%0d_count", i), count, tbl[i].cnt);
            chk($sformatf("vec%0d_full", i), full, tbl[i].fl);
            chk($sformatf("vec%0d_overflow", i), overflow, tbl[i].ovf);
            chk($sformatf("vec%0d_empty", i), empty, tbl[i].cnt == 0);
        end
        wr_en = 1'b0; ovf_clear = 1'b0; hold_busy = 1'b0;
        wait_idle(1000, "fill");

        // Move the pointers to 14 so the next test wraps them.
        for (int i = 0; i < 12; i++) put(8'h80 + 8'(i));
        wait_idle(1000, "pad");

        // Simultaneous write and pop at count 5.
        hold_busy = 1'b1;
        for (int i = 0; i < 6; i++) put(8'h50 + 8'(i));
        repeat (20) tick();
        chk("c5_pre_count", count, 5);
        hold_busy = 1'b0;
        tick();
        chk("c5_E_count", count, 5);
        chk("c5_E_begin", tx_begin, 0);
        put(8'h56);
        chk("c5_same_count", count, 5);
        tick();
        chk("c5_launch_begin", tx_begin, 1);
        chk("c5_launch_count", count, 5);
        wait_idle(1000, "c5");

        // Reset in WAIT_DONE with three bytes queued.
        hold_busy = 1'b1;
        for (int i = 0; i < 4; i++) put(8'h70 + 8'(i));
        repeat (10) tick();
        chk("rr_pre_count", count, 3);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        exp_q.delete();
        chk_reset_values("rr");
        repeat (3) tick();
        hold_busy = 1'b0;
        b0 = n_begin;
        repeat (20) tick();
        chk("rr_no_begin", n_begin - b0, 0);
        put(8'h3C);
        wait_idle(200, "rr");
        chk("rr_relaunch", n_begin - b0, 1);

        // Transmitter raising busy 5 cycles late.
        busy_delay = 5;
        b0 = n_begin;
        put(8'h11);
        put(8'h22);
        wait_idle(500, "dly");
        chk("dly_begins", n_begin - b0, 2);
        busy_delay = 0;

        // Random traffic; occupancy bound is bytes written minus bytes launched.
        rnd_busy = 1'b1;
        wb = n_wr;
        b0 = n_begin;
        for (int c = 0; c < 3000; c++) begin
            ub = (n_wr - wb) - (n_begin - b0);
            chk("rand_count_window", int'(count) == ub || int'(count) + 1 == ub, 1);
            chk("rand_overflow", overflow, 0);
            wr_en = ($urandom_range(0, 2) != 0) && ub < DEPTH;
            wr_data = 8'($urandom);
            ovf_clear = 1'($urandom);
            if (wr_en) begin
                exp_q.push_back(wr_data);
                n_wr++;
            end
            tick();
        end
        wr_en = 1'b0; ovf_clear = 1'b0;
        wait_idle(2000, "rand");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end
endmodule
